object_plotter: RTL and testbench

- Consumer side of the game-logic → display interface.
- Samples a rectangle-update request: startPlot pulse with object code, new/old corner and size.
- Erases the old rectangle in background colour, then draws the new rectangle in the object's colour.
- Emits one pixel per cycle on the x/y/colour/plot port of the 160x120 VGA adapter.

---
 rtl/plot_pkg.sv | 36 +++
 rtl/rect_scanner.sv | 57 +++++
 rtl/object_plotter.sv | 156 +++++++++++++++
 tb/tb_object_plotter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// Shared definitions for the object plotter: object codes, colours, FSM states
// and the visible screen limits of the 160x120 adapter.
package plot_pkg;

    localparam int SCREEN_MAX_X = 159;
    localparam int SCREEN_MAX_Y = 119;

    typedef enum logic [1:0] {
        BALL_OBJ   = 2'b00,
        PADDLE_OBJ = 2'b01,
        BLOCK_OBJ  = 2'b10,
        NO_OBJ     = 2'b11
    } obj_e;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BALL   = 3'b111;
    localparam logic [2:0] COL_PADDLE = 3'b010;
    localparam logic [2:0] COL_BLOCK  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_FINISH
    } state_e;

    function automatic logic [2:0] obj_colour(input obj_e obj);
        case (obj)
            BALL_OBJ:   obj_colour = COL_BALL;
            PADDLE_OBJ: obj_colour = COL_PADDLE;
            BLOCK_OBJ:  obj_colour = COL_BLOCK;
            default:    obj_colour = COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Column-inner / row-outer offset counter over a sizeX x sizeY rectangle.
// Presents the pixel at the current offset plus its on-screen and last flags.
module rect_scanner #(
    parameter int MAX_X = 159,
    parameter int MAX_Y = 119
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_step,
    input  logic [7:0] i_sizeX,
    input  logic [6:0] i_sizeY,
    input  logic [7:0] i_baseX,
    input  logic [6:0] i_baseY,
    output logic [7:0] o_pixX,
    output logic [6:0] o_pixY,
    output logic       o_inBounds,
    output logic       o_last
);
    localparam logic [8:0] LIM_X = 9'(MAX_X);
    localparam logic [7:0] LIM_Y = 8'(MAX_Y);

    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic [8:0] w_sumX;
    logic [7:0] w_sumY;
    logic       w_endX;
    logic       w_endY;

    // Sums are one bit wider so pixels past the screen edge don't wrap back on.
    assign w_sumX     = {1'b0, i_baseX} + {1'b0, r_cx};
    assign w_sumY     = {1'b0, i_baseY} + {1'b0, r_cy};
    assign w_endX     = (r_cx == i_sizeX - 8'd1);
    assign w_endY     = (r_cy == i_sizeY - 7'd1);
    assign o_last     = w_endX & w_endY;
    assign o_pixX     = w_sumX[7:0];
    assign o_pixY     = w_sumY[6:0];
    assign o_inBounds = (w_sumX <= LIM_X) && (w_sumY <= LIM_Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_clr) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_step) begin
            if (w_endX) begin
                r_cx <= '0;
                r_cy <= w_endY ? 7'd0 : r_cy + 7'd1;
            end else begin
                r_cx <= r_cx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/object_plotter.sv
// Erases an object's old rectangle and draws its new one, one pixel per cycle,
// on the x/y/colour/plot port of the VGA adapter.
module object_plotter
    import plot_pkg::*;
#(
    parameter int         MAX_X     = SCREEN_MAX_X,
    parameter int         MAX_Y     = SCREEN_MAX_Y,
    parameter logic [2:0] BG_COLOUR = COL_BLACK,
    parameter bit         ERASE_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startPlot,
    input  logic [1:0] object,
    input  logic [7:0] newX,
    input  logic [6:0] newY,
    input  logic [7:0] oldX,
    input  logic [6:0] oldY,
    input  logic [7:0] sizeX,
    input  logic [6:0] sizeY,
    output logic [7:0] vgaX,
    output logic [6:0] vgaY,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun
);
    state_e     r_state, w_cur, w_nstate, w_first;
    obj_e       r_obj, w_obj;
    logic [7:0] r_newX, r_oldX, r_sizeX, w_newX, w_oldX, w_sizeX, w_baseX;
    logic [6:0] r_newY, r_oldY, r_sizeY, w_newY, w_oldY, w_sizeY, w_baseY;
    logic [7:0] r_vgaX, w_pixX;
    logic [6:0] r_vgaY, w_pixY;
    logic [2:0] r_colour, w_colour;
    logic       r_plot, r_busy, r_done, r_overrun;
    logic       w_idle, w_accept, w_nz, w_scan, w_last, w_inBounds;

    // The done cycle still reports busy, so it also refuses new requests.
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = startPlot & ~r_busy;

    // The accepting edge already emits the first pixel, so it reads the ports directly.
    assign w_obj   = w_idle ? obj_e'(object) : r_obj;
    assign w_newX  = w_idle ? newX  : r_newX;
    assign w_newY  = w_idle ? newY  : r_newY;
    assign w_oldX  = w_idle ? oldX  : r_oldX;
    assign w_oldY  = w_idle ? oldY  : r_oldY;
    assign w_sizeX = w_idle ? sizeX : r_sizeX;
    assign w_sizeY = w_idle ? sizeY : r_sizeY;
    assign w_nz    = (w_sizeX != 8'd0) && (w_sizeY != 7'd0);

    always_comb begin
        w_first = S_FINISH;
        if (ERASE_EN && w_nz)
            w_first = S_ERASE;
        else if (w_nz && (w_obj != NO_OBJ))
            w_first = S_DRAW;
    end

    // w_cur is the phase whose output is registered on the coming edge.
    always_comb begin
        w_cur = r_state;
        if (w_idle)
            w_cur = w_accept ? w_first : S_IDLE;
    end

    assign w_scan   = (w_cur == S_ERASE) || (w_cur == S_DRAW);
    assign w_baseX  = (w_cur == S_ERASE) ? w_oldX : w_newX;
    assign w_baseY  = (w_cur == S_ERASE) ? w_oldY : w_newY;
    assign w_colour = (w_cur == S_ERASE) ? BG_COLOUR : obj_colour(w_obj);

    always_comb begin
        w_nstate = w_cur;
        case (w_cur)
            S_ERASE:  if (w_last) w_nstate = (w_obj == NO_OBJ) ? S_FINISH : S_DRAW;
            S_DRAW:   if (w_last) w_nstate = S_FINISH;
            S_FINISH: w_nstate = S_IDLE;
            default:  w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nstate;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_obj   <= BALL_OBJ;
            r_newX  <= '0;
            r_newY  <= '0;
            r_oldX  <= '0;
            r_oldY  <= '0;
            r_sizeX <= '0;
            r_sizeY <= '0;
        end else if (w_accept) begin
            r_obj   <= obj_e'(object);
            r_newX  <= newX;
            r_newY  <= newY;
            r_oldX  <= oldX;
            r_oldY  <= oldY;
            r_sizeX <= sizeX;
            r_sizeY <= sizeY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vgaX    <= '0;
            r_vgaY    <= '0;
            r_colour  <= '0;
            r_plot    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_plot    <= w_scan & w_inBounds;
            r_busy    <= (w_cur != S_IDLE);
            r_done    <= (w_cur == S_FINISH);
            r_overrun <= startPlot & r_busy;
            if (w_scan) begin
                r_vgaX   <= w_pixX;
                r_vgaY   <= w_pixY;
                r_colour <= w_colour;
            end
        end
    end

    rect_scanner #(
        .MAX_X(MAX_X),
        .MAX_Y(MAX_Y)
    ) u_scan (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (~w_scan),
        .i_step    (w_scan),
        .i_sizeX   (w_sizeX),
        .i_sizeY   (w_sizeY),
        .i_baseX   (w_baseX),
        .i_baseY   (w_baseY),
        .o_pixX    (w_pixX),
        .o_pixY    (w_pixY),
        .o_inBounds(w_inBounds),
        .o_last    (w_last)
    );

    assign vgaX    = r_vgaX;
    assign vgaY    = r_vgaY;
    assign colour  = r_colour;
    assign plot    = r_plot;
    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_object_plotter.sv
// Directed bench for object_plotter: a request table with hand-computed counts
// and a per-cycle pixel model, plus reset and overrun sequences.
module tb_object_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start0;
    logic [1:0] object;
    logic [7:0] newX, oldX, sizeX;
    logic [6:0] newY, oldY, sizeY;

    logic [7:0] x1, x0;
    logic [6:0] y1, y0;
    logic [2:0] c1, c0;
    logic       p1, p0, b1, b0, d1, d0, o1, o0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    object_plotter #(.ERASE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .startPlot(start1), .object(object),
        .newX(newX), .newY(newY), .oldX(oldX), .oldY(oldY),
        .sizeX(sizeX), .sizeY(sizeY),
        .vgaX(x1), .vgaY(y1), .colour(c1), .plot(p1),
        .busy(b1), .done(d1), .overrun(o1)
    );

    object_plotter #(.ERASE_EN(1'b0)) dut_ne (
        .clk(clk), .reset(reset), .startPlot(start0), .object(object),
        .newX(newX), .newY(newY), .oldX(oldX), .oldY(oldY),
        .sizeX(sizeX), .sizeY(sizeY),
        .vgaX(x0), .vgaY(y0), .colour(c0), .plot(p0),
        .busy(b0), .done(d0), .overrun(o0)
    );

    typedef struct {
        int obj;
        int nx, ny, ox, oy, sx, sy;
        int ee;       // 1: erase-enabled instance, 0: no-erase instance
        int ovr;      // cycle on which a second strobe is sent (0 = none)
        int exp_bg;   // plotted pixels in background colour
        int exp_fg;   // plotted pixels in object colour
        int exp_done; // cycle after the strobe on which done pulses
    } vec_t;

    vec_t vecs[9];

    function automatic int fg_col(input int obj);
        case (obj)
            0: fg_col = 7;
            1: fg_col = 2;
            2: fg_col = 4;
            default: fg_col = 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_req(input string tag, input vec_t v);
        int n, e, d, t, k, bx, by, col, ex, ey;
        int bg, fg, done_cyc, ovr_cnt, seqerr;
        logic scan, ep;
        logic [7:0] ax;
        logic [6:0] ay;
        logic [2:0] ac;
        logic ap, ab, ad, ao;
        string first;
        n  = v.sx * v.sy;
        e  = (v.ee != 0 && n != 0) ? n : 0;
        d  = (n != 0 && v.obj != 3) ? n : 0;
        t  = e + d + 1;
        bg = 0; fg = 0; done_cyc = 0; ovr_cnt = 0; seqerr = 0; first = "";
        @(negedge clk);
        object = 2'(v.obj);
        newX = 8'(v.nx); newY = 7'(v.ny);
        oldX = 8'(v.ox); oldY = 7'(v.oy);
        sizeX = 8'(v.sx); sizeY = 7'(v.sy);
        if (v.ee != 0) start1 = 1'b1; else start0 = 1'b1;
        for (int c = 1; c <= t + 2; c++) begin
            @(posedge clk);
            #1;
            // Scramble the request ports: the plotter must work from its latched copy.
            start1 = 1'b0; start0 = 1'b0;
            object = 2'($urandom); newX = 8'($urandom); newY = 7'($urandom);
            oldX = 8'($urandom); oldY = 7'($urandom);
            sizeX = 8'($urandom); sizeY = 7'($urandom);
            if (v.ee != 0) begin ax = x1; ay = y1; ac = c1; ap = p1; ab = b1; ad = d1; ao = o1; end
            else           begin ax = x0; ay = y0; ac = c0; ap = p0; ab = b0; ad = d0; ao = o0; end
            if (ap && ac == 3'b000) bg++;
            if (ap && ac != 3'b000) fg++;
            if (ad && done_cyc == 0) done_cyc = c;
            if (ao) ovr_cnt++;
            scan = 1'b0; k = 0; bx = 0; by = 0; col = 0;
            if (c <= e) begin
                scan = 1'b1; k = c - 1; bx = v.ox; by = v.oy; col = 0;
            end else if (c <= e + d) begin
                scan = 1'b1; k = c - 1 - e; bx = v.nx; by = v.ny; col = fg_col(v.obj);
            end
            if (scan) begin
                ex = bx + k % v.sx;
                ey = by + k / v.sx;
                ep = (ex <= 159) && (ey <= 119);
                if (ap != ep || !ab || ad ||
                    (ep && (int'(ax) != ex || int'(ay) != ey || int'(ac) != col))) begin
                    if (seqerr == 0)
                        first = $sformatf("cyc %0d got p%0d (%0d,%0d) c%0d b%0d d%0d need p%0d (%0d,%0d) c%0d",
                                          c, ap, ax, ay, ac, ab, ad, ep, ex, ey, col);
                    seqerr++;
                end
            end else if (ap || ab != (c == t) || ad != (c == t)) begin
                if (seqerr == 0)
                    first = $sformatf("cyc %0d got p%0d b%0d d%0d need p0 b%0d d%0d",
                                      c, ap, ab, ad, c == t, c == t);
                seqerr++;
            end
            if (c == v.ovr) begin
                if (v.ee != 0) start1 = 1'b1; else start0 = 1'b1;
            end
        end
        check({tag, " done_cycle"}, done_cyc, v.exp_done);
        check({tag, " bg_pixels"}, bg, v.exp_bg);
        check({tag, " fg_pixels"}, fg, v.exp_fg);
        check({tag, " overruns"}, ovr_cnt, (v.ovr != 0) ? 1 : 0);
        checks++;
        if (seqerr != 0) begin
            errors++;
            $display("FAIL %s sequence: %0d bad cycles, first %s", tag, seqerr, first);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        //            obj  nx  ny  ox  oy  sx sy ee ovr  bg  fg done
        vecs[0] = '{0,  51,  4, 50,  3,  4, 4, 1, 0, 16, 16, 33}; // ball
        vecs[1] = '{1,  99,117,100,117, 20, 1, 1, 0, 20, 20, 41}; // paddle
        vecs[2] = '{0, 157,117,  0,  0,  4, 4, 0, 0,  0,  9, 17}; // clipped, no erase
        vecs[3] = '{3,  20, 20, 10, 10,  4, 4, 1, 0, 16,  0, 17}; // no object
        vecs[4] = '{0,  30, 30, 31, 31,  0, 3, 1, 0,  0,  0,  1}; // zero size
        vecs[5] = '{2,   5,  6, 90, 90,  3, 2, 0, 0,  0,  6,  7}; // block, no erase
        vecs[6] = '{2, 159,119,158,118,  1, 1, 1, 0,  1,  1,  3}; // 1x1 at corner
        vecs[7] = '{0,   0,  0,159,119,  2, 2, 1, 0,  1,  4,  9}; // clipped erase
        vecs[8] = '{0,  51,  4, 50,  3,  4, 4, 1, 5, 16, 16, 33}; // overrun mid-scan

        reset = 1'b1; start1 = 1'b0; start0 = 1'b0;
        object = '0; newX = '0; newY = '0; oldX = '0; oldY = '0; sizeX = '0; sizeY = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({x1, y1, c1, p1, b1, d1, o1}), 0);
        check("reset_outputs_ne", int'({x0, y0, c0, p0, b0, d0, o0}), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_req($sformatf("vec%0d", i), vecs[i]);

        // Strobe landing on the done cycle must be refused and flagged.
        begin
            vec_t v;
            v = '{0, 1, 1, 0, 0, 2, 2, 1, 9, 4, 4, 9};
            run_req("ovr_at_done", v);
        end

        // Reset while drawing pixel 3: outputs drop without waiting for a clock.
        @(negedge clk);
        object = 2'd0; newX = 8'd51; newY = 7'd4; oldX = 8'd50; oldY = 7'd3;
        sizeX = 8'd4; sizeY = 7'd4; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre_reset_draw_x", int'(x1), 54);
        check("pre_reset_draw_col", int'(c1), 7);
        reset = 1'b1;
        #1;
        check("async_reset_pbd", int'({p1, b1, d1}), 0);
        check("async_reset_xy", int'({x1, y1, c1}), 0);
        @(negedge clk);
        reset = 1'b0;
        run_req("after_reset", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
